jtag_bscan_core: RTL and testbench



---
 rtl/jtag_bscan_core.sv | 203 ++++++++++++++++++++
 tb/tb_jtag_bscan_core.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_bscan_core.sv
// IEEE 1149.1-style TAP with IR, IDCODE, BYPASS and an N_CH-channel boundary-scan register.
// Define JTAG_INTEST_EN to add INTEST (opcode 4) and the CORE_OUT update-cell mux.
module jtag_bscan_core #(
    parameter int          N_CH       = 4,
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic            TCK,
    input  logic            TRST,
    input  logic            TMS,
    input  logic            TDI,
    output logic            TDO,
    output logic            TDO_EN,
    input  logic [N_CH-1:0] CORE_IN,
    input  logic [N_CH-1:0] PIN_IN,
    output logic [N_CH-1:0] CORE_OUT,
    output logic [N_CH-1:0] PIN_OUT
);

    localparam int BSR_W = 2 * N_CH;

    localparam logic [IR_W-1:0] OP_IDCODE  = IR_W'(1);
    localparam logic [IR_W-1:0] OP_SAMPLE  = IR_W'(2);
    localparam logic [IR_W-1:0] OP_EXTEST  = IR_W'(3);
`ifdef JTAG_INTEST_EN
    localparam logic [IR_W-1:0] OP_INTEST  = IR_W'(4);
`endif
    localparam logic [IR_W-1:0] IR_CAPTURE = {{(IR_W-2){1'b0}}, 2'b01};

    typedef enum logic [3:0] {
        TLR, RTI,
        SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
        SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
    } tap_state_t;

    tap_state_t state_q, state_d;

    logic [IR_W-1:0]  ir_shift;
    logic [IR_W-1:0]  ir_active;
    logic             bypass_q;
    logic [31:0]      id_q;
    logic [BSR_W-1:0] bsr_q;
    logic [N_CH-1:0]  upd_out_q;
`ifdef JTAG_INTEST_EN
    logic [N_CH-1:0]  upd_in_q;
    logic             is_intest;
`endif

    logic sel_id;
    logic sel_bsr;
    logic sel_byp;
    logic is_extest;
    logic tdo_d;
    logic tdo_en_d;
    logic tdo_q;
    logic tdo_en_q;

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TLR:      state_d = TMS ? TLR      : RTI;
            RTI:      state_d = TMS ? SEL_DR   : RTI;
            SEL_DR:   state_d = TMS ? SEL_IR   : CAP_DR;
            CAP_DR:   state_d = TMS ? EXIT1_DR : SHIFT_DR;
            SHIFT_DR: state_d = TMS ? EXIT1_DR : SHIFT_DR;
            EXIT1_DR: state_d = TMS ? UPD_DR   : PAUSE_DR;
            PAUSE_DR: state_d = TMS ? EXIT2_DR : PAUSE_DR;
            EXIT2_DR: state_d = TMS ? UPD_DR   : SHIFT_DR;
            UPD_DR:   state_d = TMS ? SEL_DR   : RTI;
            SEL_IR:   state_d = TMS ? TLR      : CAP_IR;
            CAP_IR:   state_d = TMS ? EXIT1_IR : SHIFT_IR;
            SHIFT_IR: state_d = TMS ? EXIT1_IR : SHIFT_IR;
            EXIT1_IR: state_d = TMS ? UPD_IR   : PAUSE_IR;
            PAUSE_IR: state_d = TMS ? EXIT2_IR : PAUSE_IR;
            EXIT2_IR: state_d = TMS ? UPD_IR   : SHIFT_IR;
            UPD_IR:   state_d = TMS ? SEL_DR   : RTI;
            default:  state_d = TLR;
        endcase
    end

    // Test-Logic-Reset re-selects IDCODE just like TRST does.
    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            ir_shift  <= '0;
            ir_active <= OP_IDCODE;
        end else if (state_q == TLR) begin
            ir_shift  <= '0;
            ir_active <= OP_IDCODE;
        end else begin
            if (state_q == CAP_IR) begin
                ir_shift <= IR_CAPTURE;
            end else if (state_q == SHIFT_IR) begin
                ir_shift <= {TDI, ir_shift[IR_W-1:1]};
            end
            if (state_q == UPD_IR) begin
                ir_active <= ir_shift;
            end
        end
    end

    always_comb begin
        sel_id    = 1'b0;
        sel_bsr   = 1'b0;
        is_extest = 1'b0;
`ifdef JTAG_INTEST_EN
        is_intest = 1'b0;
`endif
        case (ir_active)
            OP_IDCODE: sel_id = 1'b1;
            OP_SAMPLE: sel_bsr = 1'b1;
            OP_EXTEST: begin
                sel_bsr   = 1'b1;
                is_extest = 1'b1;
            end
`ifdef JTAG_INTEST_EN
            OP_INTEST: begin
                sel_bsr   = 1'b1;
                is_intest = 1'b1;
            end
`endif
            default: ;
        endcase
        sel_byp = !sel_id && !sel_bsr;
    end

    always_ff @(posedge TCK or posedge TRST) begin
        if (TRST) begin
            bypass_q  <= 1'b0;
            id_q      <= '0;
            bsr_q     <= '0;
            upd_out_q <= '0;
`ifdef JTAG_INTEST_EN
            upd_in_q  <= '0;
`endif
        end else begin
            if (state_q == CAP_DR) begin
                if (sel_byp) bypass_q <= 1'b0;
                if (sel_id)  id_q     <= IDCODE_VAL;
                if (sel_bsr) bsr_q    <= {CORE_IN, PIN_IN};
            end else if (state_q == SHIFT_DR) begin
                if (sel_byp) bypass_q <= TDI;
                if (sel_id)  id_q     <= {TDI, id_q[31:1]};
                if (sel_bsr) bsr_q    <= {TDI, bsr_q[BSR_W-1:1]};
            end
            if (state_q == UPD_DR && sel_bsr) begin
                upd_out_q <= bsr_q[BSR_W-1:N_CH];
`ifdef JTAG_INTEST_EN
                upd_in_q  <= bsr_q[N_CH-1:0];
`endif
            end
        end
    end

    always_comb begin
        tdo_d    = 1'b0;
        tdo_en_d = 1'b0;
        if (state_q == SHIFT_IR) begin
            tdo_d    = ir_shift[0];
            tdo_en_d = 1'b1;
        end else if (state_q == SHIFT_DR) begin
            tdo_en_d = 1'b1;
            if (sel_id) begin
                tdo_d = id_q[0];
            end else if (sel_bsr) begin
                tdo_d = bsr_q[0];
            end else begin
                tdo_d = bypass_q;
            end
        end
    end

    // Falling-edge launch gives the receiving device half a cycle of setup.
    always_ff @(negedge TCK or posedge TRST) begin
        if (TRST) begin
            tdo_q    <= 1'b0;
            tdo_en_q <= 1'b0;
        end else begin
            tdo_q    <= tdo_d;
            tdo_en_q <= tdo_en_d;
        end
    end

    assign TDO    = tdo_q;
    assign TDO_EN = tdo_en_q;

    always_comb begin
        PIN_OUT = is_extest ? upd_out_q : CORE_IN;
`ifdef JTAG_INTEST_EN
        CORE_OUT = is_intest ? upd_in_q : PIN_IN;
`else
        CORE_OUT = PIN_IN;
`endif
    end

endmodule

// File: tb/tb_jtag_bscan_core.sv
// Directed self-checking bench for jtag_bscan_core (N_CH=4, IR_W=4).
module tb_jtag_bscan_core;

    localparam logic [31:0] IDC = 32'h1000_0001;

    logic       TCK = 1'b0;
    logic       TRST = 1'b0;
    logic       TMS = 1'b1;
    logic       TDI = 1'b0;
    logic       TDO;
    logic       TDO_EN;
    logic [3:0] CORE_IN = 4'h3;
    logic [3:0] PIN_IN = 4'hC;
    logic [3:0] CORE_OUT;
    logic [3:0] PIN_OUT;

    int vectors = 0;
    int miscompares = 0;

    jtag_bscan_core #(
        .N_CH(4),
        .IR_W(4),
        .IDCODE_VAL(IDC)
    ) dut (
        .TCK(TCK),
        .TRST(TRST),
        .TMS(TMS),
        .TDI(TDI),
        .TDO(TDO),
        .TDO_EN(TDO_EN),
        .CORE_IN(CORE_IN),
        .PIN_IN(PIN_IN),
        .CORE_OUT(CORE_OUT),
        .PIN_OUT(PIN_OUT)
    );

    always #5 TCK = ~TCK;

    task automatic tick(input logic tms, input logic tdi,
                        output logic tdo_s, output logic en_s);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        #1;
        tdo_s = TDO;
        en_s  = TDO_EN;
        @(posedge TCK);
        #1;
    endtask

    task automatic step(input logic tms);
        logic t, e;
        tick(tms, 1'b0, t, e);
    endtask

    task automatic shift_bits(input int n, input logic [63:0] din,
                              input logic exit_last,
                              output logic [63:0] dout, output int en_low);
        logic t, e;
        dout   = '0;
        en_low = 0;
        for (int i = 0; i < n; i++) begin
            tick(exit_last && (i == n - 1), din[i], t, e);
            dout[i] = t;
            if (e !== 1'b1) en_low++;
        end
    endtask

    task automatic goto_shift_dr();
        step(1'b1);
        step(1'b0);
        step(1'b0);
    endtask

    task automatic finish_scan();
        step(1'b1);
        step(1'b0);
    endtask

    task automatic scan_dr(input int n, input logic [63:0] din,
                           output logic [63:0] dout, output int en_low);
        goto_shift_dr();
        shift_bits(n, din, 1'b1, dout, en_low);
        finish_scan();
    endtask

    task automatic load_ir(input logic [3:0] op, output logic [3:0] cap);
        logic [63:0] d;
        int e;
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        shift_bits(4, {60'd0, op}, 1'b1, d, e);
        cap = d[3:0];
        finish_scan();
    endtask

    task automatic test_reset();
        logic [63:0] d;
        int e;
        TRST = 1'b0;
        #1 TRST = 1'b1;
        #11;
        vectors++;
        if (TDO !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tdo: got %b expected 0", TDO);
        end
        vectors++;
        if (TDO_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_tdo_en: got %b expected 0", TDO_EN);
        end
        vectors++;
        if (CORE_OUT !== 4'hC) begin
            miscompares++;
            $display("FAIL reset_core_out: got %h expected c", CORE_OUT);
        end
        vectors++;
        if (PIN_OUT !== 4'h3) begin
            miscompares++;
            $display("FAIL reset_pin_out: got %h expected 3", PIN_OUT);
        end
        TRST = 1'b0;
        step(1'b0);
        scan_dr(32, 64'd0, d, e);
        vectors++;
        if (d[31:0] !== IDC) begin
            miscompares++;
            $display("FAIL reset_idcode: got %h expected %h", d[31:0], IDC);
        end
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL reset_idcode_en: got %0d low samples expected 0", e);
        end
    endtask

    task automatic test_tms_reset();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        load_ir(4'hF, cap);
        vectors++;
        if (cap !== 4'b0001) begin
            miscompares++;
            $display("FAIL ir_capture: got %b expected 0001", cap);
        end
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b0);
        for (int i = 0; i < 5; i++) step(1'b1);
        vectors++;
        if (TDO_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL tlr_tdo_en: got %b expected 0", TDO_EN);
        end
        step(1'b0);
        scan_dr(32, 64'd0, d, e);
        vectors++;
        if (d[31:0] !== IDC) begin
            miscompares++;
            $display("FAIL tms_reset_idcode: got %h expected %h", d[31:0], IDC);
        end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        load_ir(4'hF, cap);
        scan_dr(9, 64'h0A5, d, e);
        vectors++;
        if (d[8:0] !== 9'h14A) begin
            miscompares++;
            $display("FAIL bypass_ones: got %h expected 14a", d[8:0]);
        end
        vectors++;
        if (e !== 0) begin
            miscompares++;
            $display("FAIL bypass_en: got %0d low samples expected 0", e);
        end
        load_ir(4'hA, cap);
        scan_dr(9, 64'h0A5, d, e);
        vectors++;
        if (d[8:0] !== 9'h14A) begin
            miscompares++;
            $display("FAIL bypass_undef: got %h expected 14a", d[8:0]);
        end
        vectors++;
        if (PIN_OUT !== 4'h3 || CORE_OUT !== 4'hC) begin
            miscompares++;
            $display("FAIL bypass_transparent: got pin %h core %h expected 3 c",
                     PIN_OUT, CORE_OUT);
        end
    endtask

    task automatic test_sample();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        CORE_IN = 4'h3;
        PIN_IN  = 4'hC;
        load_ir(4'h2, cap);
        scan_dr(8, 64'h5A, d, e);
        vectors++;
        if (d[7:0] !== 8'h3C) begin
            miscompares++;
            $display("FAIL sample_capture: got %h expected 3c", d[7:0]);
        end
        vectors++;
        if (PIN_OUT !== 4'h3 || CORE_OUT !== 4'hC) begin
            miscompares++;
            $display("FAIL sample_transparent: got pin %h core %h expected 3 c",
                     PIN_OUT, CORE_OUT);
        end
    endtask

    task automatic test_extest();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        load_ir(4'h3, cap);
        vectors++;
        if (PIN_OUT !== 4'h5) begin
            miscompares++;
            $display("FAIL extest_preload: got %h expected 5", PIN_OUT);
        end
        PIN_IN = 4'h6;
        #1;
        vectors++;
        if (CORE_OUT !== 4'h6) begin
            miscompares++;
            $display("FAIL extest_core_out: got %h expected 6", CORE_OUT);
        end
        scan_dr(8, 64'hA3, d, e);
        vectors++;
        if (d[7:0] !== 8'h36) begin
            miscompares++;
            $display("FAIL extest_capture: got %h expected 36", d[7:0]);
        end
        vectors++;
        if (PIN_OUT !== 4'hA) begin
            miscompares++;
            $display("FAIL extest_update: got %h expected a", PIN_OUT);
        end
        load_ir(4'h1, cap);
        vectors++;
        if (PIN_OUT !== 4'h3) begin
            miscompares++;
            $display("FAIL extest_release: got %h expected 3", PIN_OUT);
        end
    endtask

    task automatic test_pause();
        logic [63:0] d1, d2;
        logic t, en;
        int e1, e2, en_hi;
        en_hi = 0;
        goto_shift_dr();
        shift_bits(16, 64'd0, 1'b1, d1, e1);
        tick(1'b0, 1'b0, t, en);
        if (en !== 1'b0) en_hi++;
        tick(1'b0, 1'b0, t, en);
        if (en !== 1'b0) en_hi++;
        tick(1'b1, 1'b0, t, en);
        if (en !== 1'b0) en_hi++;
        tick(1'b0, 1'b0, t, en);
        if (en !== 1'b0) en_hi++;
        shift_bits(16, 64'd0, 1'b1, d2, e2);
        finish_scan();
        vectors++;
        if ({d2[15:0], d1[15:0]} !== IDC) begin
            miscompares++;
            $display("FAIL pause_idcode: got %h expected %h",
                     {d2[15:0], d1[15:0]}, IDC);
        end
        vectors++;
        if (en_hi !== 0 || e1 + e2 !== 0) begin
            miscompares++;
            $display("FAIL pause_tdo_en: got %0d high pause and %0d low shift expected 0 0",
                     en_hi, e1 + e2);
        end
    endtask

    task automatic test_intest();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        CORE_IN = 4'h3;
        PIN_IN  = 4'hC;
        load_ir(4'h4, cap);
`ifdef JTAG_INTEST_EN
        scan_dr(8, 64'hF0, d, e);
        vectors++;
        if (d[7:0] !== 8'h3C) begin
            miscompares++;
            $display("FAIL intest_capture: got %h expected 3c", d[7:0]);
        end
        vectors++;
        if (CORE_OUT !== 4'h0 || PIN_OUT !== 4'h3) begin
            miscompares++;
            $display("FAIL intest_outputs: got core %h pin %h expected 0 3",
                     CORE_OUT, PIN_OUT);
        end
`else
        scan_dr(9, 64'h0F0, d, e);
        vectors++;
        if (d[8:0] !== 9'h1E0) begin
            miscompares++;
            $display("FAIL intest_bypass: got %h expected 1e0", d[8:0]);
        end
        vectors++;
        if (CORE_OUT !== 4'hC || PIN_OUT !== 4'h3) begin
            miscompares++;
            $display("FAIL intest_outputs: got core %h pin %h expected c 3",
                     CORE_OUT, PIN_OUT);
        end
`endif
    endtask

    task automatic test_trst_mid_shift();
        logic [63:0] d;
        logic [3:0] cap;
        int e;
        load_ir(4'h3, cap);
        goto_shift_dr();
        shift_bits(3, 64'h7, 1'b0, d, e);
        TRST = 1'b1;
        #3;
        vectors++;
        if (PIN_OUT !== 4'h3 || TDO_EN !== 1'b0) begin
            miscompares++;
            $display("FAIL trst_mid: got pin %h en %b expected 3 0", PIN_OUT, TDO_EN);
        end
        TRST = 1'b0;
        step(1'b0);
        scan_dr(32, 64'd0, d, e);
        vectors++;
        if (d[31:0] !== IDC) begin
            miscompares++;
            $display("FAIL trst_mid_idcode: got %h expected %h", d[31:0], IDC);
        end
    endtask

    initial begin
        test_reset();
        test_tms_reset();
        test_bypass();
        test_sample();
        test_extest();
        test_pause();
        test_intest();
        test_trst_mid_shift();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
